// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default configuration for the regfile_mp slice.
//   state_e        : array state (CLEAR sweep / READY for use)
//   DEF_*          : default values for the regfile_mp parameters
package regfile_pkg;

    localparam int unsigned DEF_ANCHO    = 64;
    localparam int unsigned DEF_PROF     = 5;
    localparam int unsigned DEF_NRD      = 2;
    localparam int unsigned DEF_ZERO_REG = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: control, write, scoreboard and read-port bundle of regfile_mp.
//   clr_i      : request full-array clear sweep
//   ready_o    : array usable
//   wren_i / wraddr_i / wrdata_i         : write port
//   setbusy_i / busyaddr_i               : scoreboard set
//   rden_i / rdaddr_i / rddata_o / rdbusy_o : NRD packed read ports
// master = requester side, slave = register file side.
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int unsigned ANCHO = DEF_ANCHO,
    parameter int unsigned PROF  = DEF_PROF,
    parameter int unsigned NRD   = DEF_NRD
) ();

    logic                  clr_i;
    logic                  ready_o;
    logic                  wren_i;
    logic [PROF-1:0]       wraddr_i;
    logic [ANCHO-1:0]      wrdata_i;
    logic                  setbusy_i;
    logic [PROF-1:0]       busyaddr_i;
    logic [NRD-1:0]        rden_i;
    logic [NRD*PROF-1:0]   rdaddr_i;
    logic [NRD*ANCHO-1:0]  rddata_o;
    logic [NRD-1:0]        rdbusy_o;

    modport master (
        output clr_i, wren_i, wraddr_i, wrdata_i, setbusy_i, busyaddr_i,
               rden_i, rdaddr_i,
        input  ready_o, rddata_o, rdbusy_o
    );

    modport slave (
        input  clr_i, wren_i, wraddr_i, wrdata_i, setbusy_i, busyaddr_i,
               rden_i, rdaddr_i,
        output ready_o, rddata_o, rdbusy_o
    );

endinterface

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port of regfile_mp.
//   i_ready           : array in READY (reads return 0 otherwise)
//   i_en / i_addr     : port enable and address
//   i_mem_data/i_busy : array entry and scoreboard bit at i_addr
//   i_wren/i_wraddr/i_wrdata : current write, used for same-cycle bypass
//   o_data_c/o_busy_c : read data and busy bit
// Optional feature: REGFILE_BYPASS_EN forwards a same-cycle write to the read.
module regfile_rdport #(
    parameter int unsigned ANCHO    = 64,
    parameter int unsigned PROF     = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic             i_ready,
    input  logic             i_en,
    input  logic [PROF-1:0]  i_addr,
    input  logic [ANCHO-1:0] i_mem_data,
    input  logic             i_busy,
    input  logic             i_wren,
    input  logic [PROF-1:0]  i_wraddr,
    input  logic [ANCHO-1:0] i_wrdata,
    output logic [ANCHO-1:0] o_data_c,
    output logic             o_busy_c
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic w_zero;
    logic w_hit;

    assign w_zero = (ZERO_REG != 0) && (i_addr == '0);
    assign w_hit  = BYPASS && i_wren && (i_addr == i_wraddr);

    // A forwarded write also retires the pending mark, so busy reads as 0.
    always_comb begin
        o_data_c = '0;
        o_busy_c = 1'b0;
        if (i_ready && i_en && !w_zero) begin
            if (w_hit) begin
                o_data_c = i_wrdata;
            end else begin
                o_data_c = i_mem_data;
                o_busy_c = i_busy;
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with pending-write scoreboard
// and a self-timed clear sweep (2**PROF cycles) after reset or clr_i.
//   clk_i  : clock, all state on rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : regfile_mp_if.slave (clear/ready, write, scoreboard, read ports)
// Optional feature: define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned ANCHO    = DEF_ANCHO,
    parameter int unsigned PROF     = DEF_PROF,
    parameter int unsigned NRD      = DEF_NRD,
    parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    regfile_mp_if.slave  bus
);

    localparam int unsigned DEPTH = 2**PROF;
    localparam logic [PROF-1:0] LAST = PROF'(DEPTH - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [PROF-1:0]   r_cnt;
    logic [PROF-1:0]   w_cnt_nxt;
    logic [ANCHO-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic              w_ready;
    logic              w_mem_we;
    logic [PROF-1:0]   w_mem_addr;
    logic [ANCHO-1:0]  w_mem_wdata;

    assign w_ready     = (r_state == READY);
    assign bus.ready_o = w_ready;

    // State and sweep counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: sweep one entry per cycle; clr_i (re)starts from entry 0.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            CLEAR: begin
                if (bus.clr_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + PROF'(1);
                end
            end
            READY: begin
                if (bus.clr_i) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Array write source: sweep zeroes r_cnt, otherwise the write port.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = bus.wraddr_i;
        w_mem_wdata = bus.wrdata_i;
        if (r_state == CLEAR) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt;
            w_mem_wdata = '0;
        end else if (bus.wren_i && !((ZERO_REG != 0) && (bus.wraddr_i == '0))) begin
            w_mem_we = 1'b1;
        end
    end

    // Storage array: no reset, contents established by the sweep.
    always_ff @(posedge clk_i) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Scoreboard update: write retires, set applied last so it wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if ((r_state == CLEAR) || bus.clr_i) begin
            w_busy_nxt = '0;
        end else begin
            if (bus.wren_i) begin
                w_busy_nxt[bus.wraddr_i] = 1'b0;
            end
            if (bus.setbusy_i) begin
                w_busy_nxt[bus.busyaddr_i] = 1'b1;
            end
            if (ZERO_REG != 0) begin
                w_busy_nxt[0] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Read ports.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [PROF-1:0]  w_addr;
        logic [ANCHO-1:0] w_data;
        logic             w_busy;

        assign w_addr = bus.rdaddr_i[k*PROF +: PROF];

        regfile_rdport #(
            .ANCHO    (ANCHO),
            .PROF     (PROF),
            .ZERO_REG (ZERO_REG)
        ) u_rdport (
            .i_ready    (w_ready),
            .i_en       (bus.rden_i[k]),
            .i_addr     (w_addr),
            .i_mem_data (r_mem[w_addr]),
            .i_busy     (r_busy[w_addr]),
            .i_wren     (bus.wren_i),
            .i_wraddr   (bus.wraddr_i),
            .i_wrdata   (bus.wrdata_i),
            .o_data_c   (w_data),
            .o_busy_c   (w_busy)
        );

        assign bus.rddata_o[k*ANCHO +: ANCHO] = w_data;
        assign bus.rdbusy_o[k]                = w_busy;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter ANCHO, default 64, data width in bits.
REQ-002 SHALL have parameter PROF, default 5, address width; depth = 2**PROF entries.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, entry 0 hardwired to zero when 1.
REQ-005 clk_i  input  1  single clock, all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous, active-low reset.
REQ-007 clr_i  input  1  request full-array clear sweep.
REQ-008 ready_o  output  1  high when array usable (state READY).
REQ-009 wren_i  input  1  write enable.
REQ-010 wraddr_i  input  PROF  write address.
REQ-011 wrdata_i  input  ANCHO  write data.
REQ-012 setbusy_i  input  1  mark entry as pending-write (scoreboard set).
REQ-013 busyaddr_i  input  PROF  scoreboard set address.
REQ-014 rden_i  input  NRD  per-port read enable.
REQ-015 rdaddr_i  input  NRD*PROF  read addresses, port k at bits [k*PROF +: PROF].
REQ-016 rddata_o  output  NRD*ANCHO  read data, port k at bits [k*ANCHO +: ANCHO].
REQ-017 rdbusy_o  output  NRD  scoreboard busy bit of addressed entry, per port.

Function
REQ-018 FSM states SHALL be CLEAR and READY; ready_o = (state == READY).
REQ-019 CLEAR SHALL write zero to entry cnt each cycle, cnt 0..2**PROF-1, then go READY; sweep takes exactly 2**PROF cycles.
REQ-020 clr_i in READY SHALL enter CLEAR with cnt=0 next cycle; clr_i in CLEAR SHALL restart cnt at 0.
REQ-021 In CLEAR, wren_i and setbusy_i SHALL be ignored; all busy bits SHALL be 0; rddata_o SHALL be 0; rdbusy_o SHALL be 0.
REQ-022 In READY, wren_i SHALL write wrdata_i to wraddr_i at the rising edge; data visible on reads the following cycle.
REQ-023 Read ports SHALL be combinational: rddata_o[k] = rden_i[k] ? mem[rdaddr k] : 0; rdbusy_o[k] = rden_i[k] ? busy[rdaddr k] : 0.
REQ-024 Same-address reads on multiple ports SHALL return identical data.
REQ-025 setbusy_i SHALL set busy[busyaddr_i]; a write (wren_i) SHALL clear busy[wraddr_i].
REQ-026 setbusy_i and wren_i to same address same cycle SHALL leave busy set (set wins); data SHALL still be written.
REQ-027 With ZERO_REG=1, writes and busy sets to entry 0 SHALL be dropped; reads of entry 0 SHALL return 0, busy 0.
REQ-028 Address out of range is impossible by construction (full 2**PROF decode); no wrap logic required.

Reset
REQ-029 rst_ni low SHALL asynchronously force state=CLEAR, cnt=0, all busy bits 0; ready_o=0, rdbusy_o=0, rddata_o=0.
REQ-030 Memory array SHALL have no reset; its zeroing is done only by the CLEAR sweep after rst_ni deasserts.
REQ-031 Reset asserted mid-sweep SHALL restart the sweep from entry 0.

Configuration
REQ-032 Macro REGFILE_BYPASS_EN defined: in READY, a read of wraddr_i with wren_i high (and not entry 0 under ZERO_REG) SHALL return wrdata_i same cycle and rdbusy_o 0.
REQ-033 Macro REGFILE_BYPASS_EN undefined: same-cycle read returns old contents and old busy bit.

Structure
REQ-034 Package regfile_pkg SHALL hold the state enum (CLEAR, READY) and default parameter constants.
REQ-035 Sub-module regfile_rdport SHALL implement one read port (enable gating, zero-reg, bypass); instantiated NRD times via generate.

Verification
REQ-036 Reset release, ANCHO=64, PROF=5 -> ready_o rises exactly 32 cycles later; all 32 entries read 0.
REQ-037 Write 0xDEAD_BEEF to 5, read port0 addr 5, port1 addr 5 next cycle -> both 0xDEAD_BEEF; write 0x1234 to 0 -> read 0 returns 0.
REQ-038 setbusy addr 7 -> rdbusy_o=1 for addr 7; wren addr 7 data 0x55 -> busy 0, data 0x55; setbusy+wren addr 9 same cycle -> busy stays 1.
REQ-039 clr_i at sweep cnt 10 -> ready_o low a further 32 cycles; writes during sweep discarded; reads 0.
REQ-040 With REGFILE_BYPASS_EN: wren addr 3 data 0xABCD, read addr 3 same cycle -> 0xABCD; without macro -> prior value.
REQ-041 rst_ni pulsed low mid-sweep and after busy set -> ready_o, rdbusy_o drop immediately; sweep restarts at entry 0.
